// File: rtl/inst_cache_pkg.sv
// Shared constants and helpers for the instruction cache and its TileLink refill engine.
package inst_cache_pkg;

  localparam logic [2:0]  TL_GET             = 3'd4;
  localparam logic [2:0]  TL_ACCESS_ACK_DATA = 3'd1;
  localparam logic [31:0] INST_NOP           = 32'h00000001;
  localparam logic        ENABLE             = 1'b1;
  localparam logic        DISABLE            = 1'b0;
  localparam int          BEAT_BYTES         = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } refill_state_e;

  function automatic logic is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

  // Halfword hw (0..3) of a 64-bit little-endian beat.
  function automatic logic [15:0] pick_parcel(input logic [63:0] beat, input logic [1:0] hw);
    return beat[{hw, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Refill engine: latches the missing line, issues one TileLink Get for it and
// streams the AccessAckData beats back to the line arrays in address order.
module icache_refill
  import inst_cache_pkg::*;
#(
  parameter int  ADDR_W     = 64,
  parameter int  LINE_BYTES = 32,
  localparam int OFF_W      = $clog2(LINE_BYTES),
  localparam int LINE_W     = ADDR_W - OFF_W,
  localparam int BEATS      = LINE_BYTES / BEAT_BYTES,
  localparam int BEAT_W     = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss,
  input  logic [LINE_W-1:0] miss_line,
  output logic              request,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_size,
  output logic [ADDR_W-1:0] a_address,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [2:0]        d_opcode,
  input  logic [63:0]       d_data,
  output logic              fill_we,
  output logic [BEAT_W-1:0] fill_beat,
  output logic [63:0]       fill_data,
  output logic              fill_done,
  output logic [LINE_W-1:0] fill_line
);

  refill_state_e     state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              beat_fire;
  logic              last_beat;

  // Only data-carrying acks advance the line; anything else on D is dropped.
  assign beat_fire = (state_q == ST_RESP) && d_valid && (d_opcode == TL_ACCESS_ACK_DATA);
  assign last_beat = beat_q == BEAT_W'(BEATS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (miss) begin
          state_d = ST_REQ;
          line_d  = miss_line;
          beat_d  = '0;
        end
      end
      ST_REQ: begin
        if (a_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (beat_fire) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    request = DISABLE;
    a_valid = DISABLE;
    d_ready = DISABLE;
    unique case (state_q)
      ST_REQ: begin
        request = ENABLE;
        a_valid = ENABLE;
      end
      ST_RESP: begin
        request = ENABLE;
        d_ready = ENABLE;
      end
      default: ;
    endcase
  end

  assign a_opcode  = TL_GET;
  assign a_size    = 3'(OFF_W);
  assign a_address = {line_q, {OFF_W{1'b0}}};
  assign fill_we   = beat_fire;
  assign fill_beat = beat_q;
  assign fill_data = d_data;
  assign fill_done = beat_fire && last_beat;
  assign fill_line = line_q;

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path with RVC
// detection and line-crossing parcels; misses refill through icache_refill.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  output logic              inst_compressed,
  output logic [31:0]       inst,
  output logic              request,
  output logic              bus_a_valid,
  input  logic              bus_a_ready,
  output logic [2:0]        bus_a_opcode,
  output logic [2:0]        bus_a_size,
  output logic [ADDR_W-1:0] bus_a_address,
  input  logic              bus_d_valid,
  output logic              bus_d_ready,
  input  logic [2:0]        bus_d_opcode,
  input  logic [63:0]       bus_d_data
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
  localparam int BEAT_W = $clog2(BEATS);

  logic [NUM_LINES-1:0][BEATS-1:0][63:0] data_q, data_d;
  logic [NUM_LINES-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic [NUM_LINES-1:0]                  valid_q, valid_d;

  logic [ADDR_W-1:0] pc2;
  logic [IDX_W-1:0]  idx0, idx1;
  logic              hit0, hit1, rvc, line_ok;
  logic [15:0]       parcel0, parcel1;
  logic              unused_lsb;

  logic              miss;
  logic [LINE_W-1:0] miss_line;
  logic              fill_we, fill_done;
  logic [BEAT_W-1:0] fill_beat;
  logic [63:0]       fill_data;
  logic [LINE_W-1:0] fill_line;

  // Upper parcel sits at pc+2, which may fall into the following line.
  assign pc2     = pc + ADDR_W'(2);
  assign idx0    = pc[OFF_W +: IDX_W];
  assign idx1    = pc2[OFF_W +: IDX_W];
  assign hit0    = valid_q[idx0] && (tag_q[idx0] == pc[ADDR_W-1 -: TAG_W]);
  assign hit1    = valid_q[idx1] && (tag_q[idx1] == pc2[ADDR_W-1 -: TAG_W]);
  assign parcel0 = pick_parcel(data_q[idx0][pc[OFF_W-1:3]], pc[2:1]);
  assign parcel1 = pick_parcel(data_q[idx1][pc2[OFF_W-1:3]], pc2[2:1]);
  assign rvc     = is_rvc(parcel0);
  assign line_ok = hit0 && (rvc || hit1);

  // The lower line is fetched first; the upper one only once the lower hits.
  assign miss       = !line_ok;
  assign miss_line  = hit0 ? pc2[ADDR_W-1:OFF_W] : pc[ADDR_W-1:OFF_W];
  assign unused_lsb = pc[0] ^ pc2[0];

  always_comb begin
    inst_valid      = DISABLE;
    inst_compressed = DISABLE;
    inst            = INST_NOP;
    if (line_ok && !request) begin
      inst_valid      = ENABLE;
      inst_compressed = rvc;
      inst            = rvc ? {16'h0000, parcel0} : {parcel1, parcel0};
    end
  end

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (fill_we) data_d[fill_line[IDX_W-1:0]][fill_beat] = fill_data;
    if (fill_done) begin
      tag_d[fill_line[IDX_W-1:0]]   = fill_line[LINE_W-1:IDX_W];
      valid_d[fill_line[IDX_W-1:0]] = ENABLE;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  icache_refill #(
    .ADDR_W    (ADDR_W),
    .LINE_BYTES(LINE_BYTES)
  ) u_refill (
    .clk      (clk),
    .rst_n    (rst_n),
    .miss     (miss),
    .miss_line(miss_line),
    .request  (request),
    .a_valid  (bus_a_valid),
    .a_ready  (bus_a_ready),
    .a_opcode (bus_a_opcode),
    .a_size   (bus_a_size),
    .a_address(bus_a_address),
    .d_valid  (bus_d_valid),
    .d_ready  (bus_d_ready),
    .d_opcode (bus_d_opcode),
    .d_data   (bus_d_data),
    .fill_we  (fill_we),
    .fill_beat(fill_beat),
    .fill_data(fill_data),
    .fill_done(fill_done),
    .fill_line(fill_line)
  );

endmodule

// File: tb/tb_inst_cache.sv
// Randomized bench for inst_cache: a TileLink memory responder plus a
// line-level cache model that predicts every output each cycle.
module tb_inst_cache;

  localparam int NUM_LINES = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc = '0;
  logic        inst_valid, inst_compressed, request;
  logic [31:0] inst;
  logic        a_valid, a_ready, d_valid, d_ready;
  logic [2:0]  a_opcode, a_size, d_opcode;
  logic [63:0] a_address, d_data;

  always #5 clk = ~clk;

  inst_cache #(.NUM_LINES(NUM_LINES), .LINE_BYTES(32), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .inst_valid(inst_valid), .inst_compressed(inst_compressed), .inst(inst),
    .request(request),
    .bus_a_valid(a_valid), .bus_a_ready(a_ready), .bus_a_opcode(a_opcode),
    .bus_a_size(a_size), .bus_a_address(a_address),
    .bus_d_valid(d_valid), .bus_d_ready(d_ready), .bus_d_opcode(d_opcode),
    .bus_d_data(d_data)
  );

  int n_chk = 0, n_fail = 0;
  logic [63:0] ovr [logic [63:0]];
  bit          m_val [NUM_LINES];
  logic [63:0] m_line [NUM_LINES];
  bit          m_pend, m_acc;
  int          m_got;
  logic [63:0] m_addr;
  int          hold_nrdy = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Backing memory: a few fixed words, everything else a hash of the address.
  function automatic logic [63:0] mem64(input logic [63:0] a);
    logic [63:0] x;
    if (ovr.exists(a)) return ovr[a];
    x = a * 64'h9E3779B97F4A7C15;
    return x ^ (x >> 29);
  endfunction

  function automatic logic [15:0] mem16(input logic [63:0] a);
    logic [63:0] w;
    w = mem64({a[63:3], 3'b000});
    return w[{a[2:1], 4'b0000} +: 16];
  endfunction

  function automatic bit line_hit(input logic [63:0] a);
    int idx;
    idx = int'((a >> 5) % NUM_LINES);
    return m_val[idx] && (m_line[idx] == (a >> 5));
  endfunction

  task automatic model_eval(output bit v, output bit c, output logic [31:0] i,
                            output bit miss, output logic [63:0] maddr);
    logic [15:0] p0, p1;
    bit h0, h1, rvc;
    p0   = mem16(pc);
    p1   = mem16(pc + 64'd2);
    h0   = line_hit(pc);
    h1   = line_hit(pc + 64'd2);
    rvc  = p0[1:0] != 2'b11;
    miss = !(h0 && (rvc || h1));
    maddr = h0 ? ((pc + 64'd2) & ~64'h1F) : (pc & ~64'h1F);
    v = !m_pend && !miss;
    c = v && rvc;
    i = !v ? 32'h00000001 : (rvc ? {16'h0000, p0} : {p1, p0});
  endtask

  // Advance the model across one clock edge using the inputs held at that edge.
  task automatic model_edge();
    bit v, c, miss;
    logic [31:0] i;
    logic [63:0] ma;
    model_eval(v, c, i, miss, ma);
    if (!m_pend) begin
      if (miss) begin
        m_pend = 1; m_acc = 0; m_got = 0; m_addr = ma;
      end
    end else if (!m_acc) begin
      if (a_ready) m_acc = 1;
    end else if (d_valid && d_opcode == 3'd1) begin
      m_got++;
      if (m_got == 4) begin
        int idx;
        idx = int'((m_addr >> 5) % NUM_LINES);
        m_val[idx]  = 1;
        m_line[idx] = m_addr >> 5;
        m_pend      = 0;
      end
    end
  endtask

  task automatic drive_bus();
    a_ready = (hold_nrdy > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (hold_nrdy > 0) hold_nrdy--;
    if (m_pend && m_acc && $urandom_range(0, 3) != 0) begin
      d_valid = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        d_opcode = 3'd0;
        d_data   = {$urandom, $urandom};
      end else begin
        d_opcode = 3'd1;
        d_data   = mem64(m_addr + 64'(8 * m_got));
      end
    end else begin
      d_valid  = 1'b0;
      d_opcode = 3'($urandom);
      d_data   = {$urandom, $urandom};
    end
  endtask

  task automatic check_all();
    bit v, c, miss;
    logic [31:0] i;
    logic [63:0] ma;
    model_eval(v, c, i, miss, ma);
    chk("inst_valid", inst_valid, v);
    chk("inst_compressed", inst_compressed, c);
    chk("inst", inst, i);
    chk("request", request, m_pend);
    chk("a_valid", a_valid, m_pend && !m_acc);
    chk("d_ready", d_ready, m_pend && m_acc);
    if (m_pend && !m_acc) begin
      chk("a_address", a_address, m_addr);
      chk("a_opcode", a_opcode, 3'd4);
      chk("a_size", a_size, 3'd5);
    end
  endtask

  task automatic cycle(input logic [63:0] npc);
    @(posedge clk); #1;
    model_edge();
    pc = npc;
    drive_bus();
    #1;
    check_all();
  endtask

  task automatic wait_idle(input logic [63:0] p, input int budget);
    int n = 0;
    do begin
      cycle(p);
      n++;
    end while (m_pend && n < budget);
    chk("refill_timeout", m_pend, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0; d_data = '0;
    m_pend = 0; m_acc = 0; m_got = 0;
    foreach (m_val[k]) m_val[k] = 0;
    #1;
    chk("rst_inst", inst, 32'h00000001);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_request", request, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_d_ready", d_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_all();
  endtask

  initial begin
    logic [63:0] addr0, rp;
    int n;
    ovr[64'h00] = 64'h00A00093_00000297;
    ovr[64'h08] = 64'h0001_0001_0001_4501;
    ovr[64'h18] = 64'h0533_0001_0001_0001;
    ovr[64'h20] = 64'h0001_0001_0001_00B5;

    do_reset();

    // Cold miss at pc 0, then hits in the filled line.
    cycle(64'h0);
    chk("cold_request", request, 1);
    chk("cold_a_address", a_address, 64'h0);
    chk("cold_a_opcode", a_opcode, 3'd4);
    chk("cold_a_size", a_size, 3'd5);
    wait_idle(64'h0, 200);
    chk("hit0_inst", inst, 32'h00000297);
    chk("hit0_valid", inst_valid, 1);
    chk("hit0_rvc", inst_compressed, 0);
    cycle(64'h4);
    chk("hit4_inst", inst, 32'h00A00093);
    chk("hit4_request", request, 0);
    cycle(64'h8);
    chk("rvc_inst", inst, 32'h00004501);
    chk("rvc_flag", inst_compressed, 1);

    // Instruction straddling lines 0x00 and 0x20.
    cycle(64'h1E);
    cycle(64'h1E);
    chk("cross_a_address", a_address, 64'h20);
    wait_idle(64'h1E, 200);
    chk("cross_inst", inst, 32'h00B50533);
    chk("cross_valid", inst_valid, 1);

    // Conflict eviction in index 0.
    cycle(64'h800);
    cycle(64'h800);
    chk("conf_a_address", a_address, 64'h800);
    wait_idle(64'h800, 200);
    cycle(64'h0);
    cycle(64'h0);
    chk("conf_back_request", request, 1);
    chk("conf_back_a_address", a_address, 64'h0);

    // Reset in the middle of the response burst.
    n = 0;
    while (!(m_acc && m_got == 2) && n < 200) begin
      cycle(64'h0);
      n++;
    end
    chk("mid_resp_reached", m_got, 2);
    do_reset();
    cycle(64'h0);
    chk("post_rst_request", request, 1);
    chk("post_rst_a_address", a_address, 64'h0);
    wait_idle(64'h0, 200);

    // A-channel backpressure.
    hold_nrdy = 7;
    cycle(64'h1000);
    cycle(64'h1000);
    addr0 = a_address;
    chk("bp_addr0", addr0, 64'h1000);
    repeat (5) begin
      cycle(64'h1000);
      chk("bp_a_valid", a_valid, 1);
      chk("bp_a_address", a_address, addr0);
    end

    // Redirect mid-response: old line completes, then the new miss is serviced.
    n = 0;
    while (!(m_acc && m_got >= 1) && n < 200) begin
      cycle(64'h1000);
      n++;
    end
    wait_idle(64'h2468, 200);
    cycle(64'h2468);
    chk("redir_request", request, 1);
    chk("redir_a_address", a_address, 64'h2460);
    wait_idle(64'h2468, 200);
    cycle(64'h1000);
    chk("redir_old_line_hit", inst_valid, 1);

    // Random fetch stream over a 4-way aliased 8 KiB window.
    rp = 64'h0;
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) begin
        rp = 64'($urandom_range(0, 16'h1FFF)) & ~64'h1;
        if ($urandom_range(0, 7) == 0) rp = rp | 64'h1E;
      end
      cycle(rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
